// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Operation codes follow the EX-stage control encoding.
package muldiv_defs;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_e;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between EX-stage control and the HI/LO unit.
// master = EX control, slave = multiply/divide unit.
interface hilo_muldiv_unit_if;

    logic        start;
    logic [1:0]  op;
    logic        we;
    logic        hilo_sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, we, hilo_sel, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, we, hilo_sel, rs_val, rt_val,
        output busy, hi, lo
    );

endinterface

// File: rtl/hilo_muldiv_unit_datapath.sv
// Combinational product / quotient / remainder for MULT(U) and DIV(U),
// including divide-by-zero and INT_MIN / -1 results.
module muldiv_datapath
    import muldiv_defs::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_dz;
    logic        w_ovf;

    // Signed divide runs on magnitudes; signs restored afterwards
    always_comb begin
        w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        w_uprod = {32'd0, i_a} * {32'd0, i_b};
        w_mag_a = i_a[31] ? (~i_a + 32'd1) : i_a;
        w_mag_b = i_b[31] ? (~i_b + 32'd1) : i_b;
        w_dz    = (i_b == 32'd0);
        w_ovf   = (i_a == INT_MIN) && (i_b == ALL_ONE);
        w_mag_q = '0;
        w_mag_r = '0;
        w_uq    = '0;
        w_ur    = '0;
        if (!w_dz) begin
            w_mag_q = w_mag_a / w_mag_b;
            w_mag_r = w_mag_a % w_mag_b;
            w_uq    = i_a / i_b;
            w_ur    = i_a % i_b;
        end
        w_sq = (i_a[31] ^ i_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
        w_sr = i_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
    end

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        unique case (i_op)
            OP_MULT: begin
                o_hi = w_sprod[63:32];
                o_lo = w_sprod[31:0];
            end
            OP_MULTU: begin
                o_hi = w_uprod[63:32];
                o_lo = w_uprod[31:0];
            end
            OP_DIV: begin
                if (w_dz) begin
                    o_hi = i_a;
                    o_lo = ALL_ONE;
                end else if (w_ovf) begin
                    o_hi = '0;
                    o_lo = INT_MIN;
                end else begin
                    o_hi = w_sr;
                    o_lo = w_sq;
                end
            end
            OP_DIVU: begin
                o_hi = w_dz ? i_a : w_ur;
                o_lo = w_dz ? ALL_ONE : w_uq;
            end
            default: begin
                o_hi = '0;
                o_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a fixed-latency multiply/divide sequencer.
// Result is computed at launch and held in shadow regs until the count expires.
module hilo_muldiv_unit
    import muldiv_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic [31:0]        w_hi;
    logic [31:0]        w_lo;

    muldiv_datapath u_dp (
        .i_op (bus.op),
        .i_a  (bus.rs_val),
        .i_b  (bus.rt_val),
        .o_hi (w_hi),
        .o_lo (w_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_res_hi <= w_hi;
                        r_res_lo <= w_lo;
                        r_busy   <= 1'b1;
                        if (bus.op[1]) begin
                            r_state <= S_DIV;
                            r_cnt   <= CNT_W'(DIV_CYCLES);
                        end else begin
                            r_state <= S_MUL;
                            r_cnt   <= CNT_W'(MULT_CYCLES);
                        end
                    end else if (bus.we) begin
                        if (bus.hilo_sel) r_hi <= bus.rs_val;
                        else              r_lo <= bus.rs_val;
                    end
                end
                S_MUL, S_DIV: begin
                    // Commit on the edge that ends the last busy cycle
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_res_hi;
                        r_lo    <= r_res_lo;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of the HI/LO multiply/divide unit
// against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // inj: 0 none, 1 extra start mid-op, 2 MTHI/MTLO mid-op
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_we, input int inj);
        logic [63:0] exp;
        int cnt;
        int n;
        exp = model(op, a, b);
        n = op[1] ? DC : MC;
        bus.start = 1'b1;
        bus.op = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.we = with_we;
        bus.hilo_sel = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.we = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 40) begin
            chk("hold_hi", bus.hi, m_hi);
            chk("hold_lo", bus.lo, m_lo);
            cnt++;
            if (inj == 1 && cnt == 2) begin
                bus.start = 1'b1;
                bus.op = ~op;
                bus.rs_val = $urandom;
                bus.rt_val = $urandom;
            end else if (inj == 2 && cnt == 2) begin
                bus.we = 1'b1;
                bus.hilo_sel = 1'($urandom);
                bus.rs_val = $urandom;
            end else begin
                bus.start = 1'b0;
                bus.we = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        bus.we = 1'b0;
        chk("busy_len", 32'(cnt), 32'(n));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        chk("res_hi", bus.hi, m_hi);
        chk("res_lo", bus.lo, m_lo);
    endtask

    task automatic mt_write(input bit sel, input logic [31:0] d);
        bus.we = 1'b1;
        bus.hilo_sel = sel;
        bus.rs_val = d;
        tick();
        bus.we = 1'b0;
        if (sel) m_hi = d;
        else     m_lo = d;
        chk(sel ? "mthi" : "mtlo", sel ? bus.hi : bus.lo, d);
        chk("mt_other", sel ? bus.lo : bus.hi, sel ? m_lo : m_hi);
    endtask

    task automatic reset_mid_div();
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.rs_val = 32'd1000;
        bus.rt_val = 32'd7;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        repeat (DC + 2) tick();
        chk("nolate_busy", 32'(bus.busy), 32'd0);
        chk("nolate_hi", bus.hi, 32'd0);
        chk("nolate_lo", bus.lo, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.we = 1'b0;
        bus.hilo_sel = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t1_lo", bus.lo, 32'hFFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("t2_hi", bus.hi, 32'hFFFF_FFFE);
        chk("t2_lo", bus.lo, 32'h0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        chk("t3_lo", bus.lo, 32'hFFFF_FFFD);
        chk("t3_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        chk("t3u_lo", bus.lo, 32'h7FFF_FFFC);
        chk("t3u_hi", bus.hi, 32'd1);
        run_op(2'b11, 32'h1234, 32'd0, 1'b0, 0);
        chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dz_hi", bus.hi, 32'h1234);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);
        mt_write(1'b0, 32'h0000_AAAA);
        mt_write(1'b1, 32'h5555_0000);
        run_op(2'b01, 32'd6, 32'd7, 1'b0, 2);
        run_op(2'b00, 32'd9, 32'hFFFF_FFFF, 1'b0, 1);
        run_op(2'b10, 32'd100, 32'd9, 1'b0, 1);
        // back-to-back launch in the first idle cycle
        run_op(2'b11, 32'd77, 32'd5, 1'b0, 0);
        reset_mid_div();
        run_op(2'b01, 32'd3, 32'd4, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                mt_write(1'($urandom), $urandom);
            end else begin
                op = 2'($urandom);
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
                if ($urandom_range(0, 7) == 0) b = 32'd0;
                if ($urandom_range(0, 9) == 0) begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                run_op(op, a, b, $urandom_range(0, 4) == 0, int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
